if_fetch_queue: RTL and testbench
=================================

Name: if_fetch_queue

Overview:
- Instruction-fetch stage directly downstream of the PC register.
- Takes the current PC, issues one instruction-memory request at a time, and pulses pc_wr so the PC register loads NPC (PC+4 from the external NPC mux) when a request is granted.
- Returned words are buffered with their PCs in a small FIFO toward decode.
- flush (branch redirect/exception) empties the queue and discards any in-flight response.

Parameters:
DEPTH, 4, queue entries; power of 2, >=2
PC_WIDTH, 32, PC/address width, bit 0 = MSB
INSTR_WIDTH, 32, instruction width, bit 0 = MSB

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  reset, synchronous, active-high
PC  in  PC_WIDTH  current PC from PC register
pc_wr  out  1  PC-register write enable; advance PC to NPC
flush  in  1  discard queue and in-flight fetch
im_req  out  1  IM request valid
im_addr  out  PC_WIDTH  IM word address = PC with bits [PC_WIDTH-2:PC_WIDTH-1] forced 0
im_gnt  in  1  IM accepts request this cycle
im_rvalid  in  1  IM read data valid; earliest one cycle after grant
im_rdata  in  INSTR_WIDTH  IM read data
instr_valid  out  1  queue head valid
instr  out  INSTR_WIDTH  head instruction
instr_pc  out  PC_WIDTH  head PC
instr_ready  in  1  decode consumes head when instr_valid && instr_ready
q_count  out  log2(DEPTH)+1  entries held

Behaviour:
- Reset (rst high at an edge): state IDLE, pointers 0, q_count 0, pend_pc 0, storage 0. Outputs: instr_valid 0, instr 0, instr_pc 0, im_req 0, pc_wr 0. Reset mid-fetch abandons the outstanding request; a later im_rvalid is ignored while in IDLE.
- Fetch FSM states: IDLE (nothing outstanding), WAIT (one outstanding, response kept), DROP (one outstanding, response discarded).
- im_req = (state==IDLE) && !flush && (q_count < DEPTH). This is combinational.
- pc_wr = im_req && im_gnt. This is combinational. On pc_wr, pend_pc <= PC and the FSM goes IDLE->WAIT. With im_req && !im_gnt, hold in IDLE with im_req asserted.
- WAIT, im_rvalid && !flush: push {pend_pc, im_rdata}, go to IDLE. A new request may issue only from the following cycle, so peak throughput is 1 instr / 2 cycles.
- WAIT, flush && !im_rvalid: go to DROP.
- WAIT, flush && im_rvalid: discard data, go to IDLE.
- DROP, im_rvalid: discard data, go to IDLE. Otherwise hold DROP; flush in DROP has no further effect.
- IDLE: im_rvalid is ignored.
- Queue:
  - Pop when instr_valid && instr_ready.
  - Simultaneous push and pop: q_count unchanged, order preserved.
  - Pointers wrap modulo DEPTH.
  - instr_valid = (q_count != 0); instr and instr_pc are the head entry.
  - Push is never attempted when full, guaranteed by the im_req space check with one outstanding request max.
- flush: next cycle q_count = 0 and pointers reset. Flush overrides pop and push that cycle. pc_wr stays 0 while flush is high; external redirect logic owns the PC write that cycle.
- Latency:
  - Grant at cycle N, rvalid at N+k: entry visible (instr_valid=1) at N+k+1.
  - Earliest next pc_wr is at N+k+1.

Test Plan:
- Reset, then PC=0x0000_0100, im_gnt=1, rvalid one cycle after grant, data 0x3860_0001, instr_ready=1 -> im_addr=0x100; pc_wr pulses every 2 cycles; first instr_valid with instr_pc=0x100, instr=0x3860_0001, in order thereafter.
- instr_ready=0, continuous grants -> exactly 4 pc_wr pulses, q_count reaches 4, im_req stays 0. Raise instr_ready -> entries drain in fetch order and im_req reasserts when q_count=3.
- q_count=3 with pop and push in the same cycle -> q_count stays 3; head and tail ordering intact across pointer wrap.
- Grant, then flush before rvalid, then rvalid 3 cycles later -> state goes to DROP; data is not pushed; q_count=0; no pc_wr during flush; im_req resumes the cycle after return to IDLE.
- flush coincident with im_rvalid while q_count=2 -> q_count=0 next cycle, response discarded, state IDLE.
- im_gnt held 0 for 5 cycles -> im_req stays high and pc_wr=0 throughout. rst asserted while in WAIT -> all outputs at reset values next cycle; late im_rvalid is ignored.

Source files
------------

// File: rtl/if_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : if_fetch_queue
// Brief    : Instruction-fetch stage with one outstanding IM request and a
//            small PC-tagged instruction FIFO toward decode.
// Revision : 1.0 - initial release
// ============================================================================
module if_fetch_queue #(
    parameter int DEPTH       = 4,
    parameter int PC_WIDTH    = 32,
    parameter int INSTR_WIDTH = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [0:PC_WIDTH-1]          PC,
    output logic                         pc_wr,
    input  logic                         flush,
    output logic                         im_req,
    output logic [0:PC_WIDTH-1]          im_addr,
    input  logic                         im_gnt,
    input  logic                         im_rvalid,
    input  logic [0:INSTR_WIDTH-1]       im_rdata,
    output logic                         instr_valid,
    output logic [0:INSTR_WIDTH-1]       instr,
    output logic [0:PC_WIDTH-1]          instr_pc,
    input  logic                         instr_ready,
    output logic [$clog2(DEPTH):0]       q_count
);

    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_cnt_w = c_ptr_w + 1;
    localparam logic [c_cnt_w-1:0] c_depth = c_cnt_w'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [0:PC_WIDTH-1]     r_pend_pc;
    logic [c_ptr_w-1:0]      r_wr_ptr;
    logic [c_ptr_w-1:0]      r_rd_ptr;
    logic [c_cnt_w-1:0]      r_count;
    logic [0:PC_WIDTH-1]     r_pc_mem   [DEPTH];
    logic [0:INSTR_WIDTH-1]  r_data_mem [DEPTH];

    logic w_push;
    logic w_pop;

    // Space check plus single-outstanding rule guarantees a push never hits a full queue
    assign im_req      = !rst && (r_state == S_IDLE) && !flush && (r_count < c_depth);
    assign pc_wr       = im_req && im_gnt;
    assign im_addr     = {PC[0:PC_WIDTH-3], 2'b00};
    assign instr_valid = (r_count != '0);
    assign instr       = r_data_mem[r_rd_ptr];
    assign instr_pc    = r_pc_mem[r_rd_ptr];
    assign q_count     = r_count;

    assign w_push = (r_state == S_WAIT) && im_rvalid && !flush;
    assign w_pop  = instr_valid && instr_ready && !flush;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (pc_wr) w_state_nxt = S_WAIT;
            S_WAIT: begin
                if (im_rvalid)  w_state_nxt = S_IDLE;
                else if (flush) w_state_nxt = S_DROP;
            end
            S_DROP: if (im_rvalid) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_pend_pc <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (pc_wr) r_pend_pc <= PC;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_pc_mem[i]   <= '0;
                r_data_mem[i] <= '0;
            end
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_pc_mem[r_wr_ptr]   <= r_pend_pc;
                r_data_mem[r_wr_ptr] <= im_rdata;
                r_wr_ptr             <= r_wr_ptr + c_ptr_w'(1);
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            r_count <= r_count + c_cnt_w'(w_push) - c_cnt_w'(w_pop);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_if_fetch_queue
// Brief    : Directed and randomized checks of if_fetch_queue against a
//            queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_if_fetch_queue;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [0:31] PC;
    logic        pc_wr;
    logic        flush;
    logic        im_req;
    logic [0:31] im_addr;
    logic        im_gnt;
    logic        im_rvalid;
    logic [0:31] im_rdata;
    logic        instr_valid;
    logic [0:31] instr;
    logic [0:31] instr_pc;
    logic        instr_ready;
    logic [2:0]  q_count;

    if_fetch_queue #(.DEPTH(DEPTH), .PC_WIDTH(32), .INSTR_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .PC(PC), .pc_wr(pc_wr), .flush(flush),
        .im_req(im_req), .im_addr(im_addr), .im_gnt(im_gnt),
        .im_rvalid(im_rvalid), .im_rdata(im_rdata),
        .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
        .instr_ready(instr_ready), .q_count(q_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int wr_seen = 0;

    // Reference: one outstanding fetch flag, a discard flag, and an ordered queue of {pc, instr}
    bit          m_out;
    bit          m_drop;
    logic [31:0] m_pend;
    logic [63:0] m_q[$];
    logic [31:0] pc_reg;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input bit r, input bit f, input bit g, input bit rv,
                        input bit rdy, input logic [31:0] d);
        bit exp_req, exp_wr, pop, push;
        rst = r; flush = f; im_gnt = g; im_rvalid = rv; im_rdata = d;
        instr_ready = rdy; PC = pc_reg;
        #1;
        exp_req = !r && !m_out && !f && (m_q.size() < DEPTH);
        exp_wr  = exp_req && g;
        if (!r) begin
            chk("im_req", im_req, exp_req);
            chk("pc_wr", pc_wr, exp_wr);
            chk("im_addr", im_addr, {pc_reg[31:2], 2'b00});
            chk("instr_valid", instr_valid, m_q.size() != 0);
            chk("q_count", q_count, m_q.size());
            if (m_q.size() != 0) begin
                chk("instr_pc", instr_pc, m_q[0][63:32]);
                chk("instr", instr, m_q[0][31:0]);
            end
        end
        if (pc_wr === 1'b1) wr_seen++;
        @(posedge clk);
        pop  = !r && !f && rdy && (m_q.size() != 0);
        push = !r && !f && m_out && !m_drop && rv;
        if (r) begin
            m_q.delete();
            m_out = 0; m_drop = 0; m_pend = '0;
        end else begin
            if (f) m_q.delete();
            else begin
                if (pop)  void'(m_q.pop_front());
                if (push) m_q.push_back({m_pend, d});
            end
            if (m_out && rv) begin
                m_out = 0; m_drop = 0;
            end else if (m_out && f) m_drop = 1;
            if (exp_wr) begin
                m_out = 1; m_drop = 0; m_pend = pc_reg;
            end
            if (f) pc_reg = $urandom & 32'hFFFF_FFFC;
            else if (exp_wr) pc_reg = pc_reg + 32'd4;
        end
        #1;
    endtask

    // Memory answers one cycle after each grant
    task automatic auto_run(input int n, input bit g, input bit rdy);
        for (int i = 0; i < n; i++) step(0, 0, g, m_out, rdy, $urandom);
    endtask

    initial begin
        rst = 1'b1; flush = 0; im_gnt = 0; im_rvalid = 0; im_rdata = '0;
        instr_ready = 0; PC = '0;
        m_out = 0; m_drop = 0; m_pend = '0; pc_reg = 32'h0000_0100;

        // Reset values
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        chk("rst_im_req", im_req, 0);
        chk("rst_pc_wr", pc_wr, 0);
        chk("rst_valid", instr_valid, 0);
        chk("rst_instr", instr, 0);
        chk("rst_instr_pc", instr_pc, 0);
        chk("rst_q_count", q_count, 0);

        // Streaming fetch from 0x100
        step(0, 0, 1, 0, 1, 0);
        step(0, 0, 1, 1, 1, 32'h3860_0001);
        chk("first_valid", instr_valid, 1);
        chk("first_pc", instr_pc, 32'h0000_0100);
        chk("first_instr", instr, 32'h3860_0001);
        auto_run(12, 1, 1);
        auto_run(4, 0, 1);

        // Fill with decode stalled, then drain across pointer wrap
        wr_seen = 0;
        auto_run(12, 1, 0);
        chk("fill_wr_pulses", wr_seen, 4);
        chk("fill_q_count", q_count, 4);
        chk("fill_im_req", im_req, 0);
        auto_run(10, 1, 1);
        auto_run(8, 0, 1);

        // Flush while a fetch is outstanding; late response dropped
        step(0, 0, 1, 0, 0, 0);
        step(0, 1, 1, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0);
        step(0, 0, 0, 1, 0, 32'hDEAD_BEEF);
        chk("drop_q_count", q_count, 0);
        chk("drop_im_req_resume", im_req, 1);

        // Flush coincident with a response while two entries held
        auto_run(4, 1, 0);
        step(0, 0, 1, 0, 0, 0);
        chk("pre_flush_q_count", q_count, 2);
        step(0, 1, 0, 1, 0, 32'hCAFE_F00D);
        chk("flush_rv_q_count", q_count, 0);
        chk("flush_rv_valid", instr_valid, 0);

        // Grant withheld
        wr_seen = 0;
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0, 0);
        chk("nogrant_wr", wr_seen, 0);
        chk("nogrant_req", im_req, 1);

        // Reset while waiting; late rvalid ignored
        step(0, 0, 1, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        chk("rst_wait_req", im_req, 0);
        chk("rst_wait_q", q_count, 0);
        chk("rst_wait_instr", instr, 0);
        chk("rst_wait_pc", instr_pc, 0);
        step(0, 0, 0, 1, 1, 32'h1234_5678);
        chk("late_rv_q", q_count, 0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            bit r, f, g, rv, rdy;
            r   = ($urandom_range(0, 199) == 0);
            f   = ($urandom_range(0, 99) < 5);
            g   = ($urandom_range(0, 99) < 70);
            rdy = ($urandom_range(0, 99) < 55);
            rv  = m_out ? ($urandom_range(0, 99) < 50) : ($urandom_range(0, 99) < 5);
            step(r, f, g, rv, rdy, $urandom);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
